// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard_if
// Brief    : DE-stage issue / writeback / stall bundle of the register scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REGNO_BITS = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_WB     = 1
);
  logic                         issue_valid_i;
  logic                         issue_wr_i;
  logic [REGNO_BITS-1:0]        issue_dst_i;
  logic [NUM_SRC-1:0]           src_use_i;
  logic [NUM_SRC*REGNO_BITS-1:0] src_regno_i;
  logic                         flush_i;
  logic [NUM_WB-1:0]            wb_valid_i;
  logic [NUM_WB*REGNO_BITS-1:0] wb_regno_i;
  logic                         stall_o;
  logic                         issue_fire_o;
  logic [NUM_REGS-1:0]          busy_vec_o;
  logic                         err_underflow_o;

  modport master (
    output issue_valid_i, issue_wr_i, issue_dst_i, src_use_i, src_regno_i,
           flush_i, wb_valid_i, wb_regno_i,
    input  stall_o, issue_fire_o, busy_vec_o, err_underflow_o
  );

  modport slave (
    input  issue_valid_i, issue_wr_i, issue_dst_i, src_use_i, src_regno_i,
           flush_i, wb_valid_i, wb_regno_i,
    output stall_o, issue_fire_o, busy_vec_o, err_underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register in-flight writer counters producing DE stall/fire.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REGNO_BITS = 5,
  parameter int CNT_BITS   = 3,
  parameter int NUM_SRC    = 2,
  parameter int NUM_WB     = 1,
  parameter int WB_BYPASS  = 0
) (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);

  localparam int                  c_rel_bits = $clog2(NUM_WB + 1);
  localparam int                  c_sum_bits = CNT_BITS + c_rel_bits + 1;
  localparam logic [CNT_BITS-1:0] c_cnt_max  = '1;

  logic [CNT_BITS-1:0]   w_count [NUM_REGS];
  logic [c_rel_bits-1:0] w_rel   [NUM_REGS];
  logic                  w_uf    [NUM_REGS];
  logic                  w_uf_any;
  logic [REGNO_BITS-1:0] w_dst;
  logic                  w_src_hazard;
  logic                  w_sat_hazard;
  logic                  w_stall;
  logic                  w_fire;
  logic                  r_err;

  // Out-of-range indices alias register 0, which is never tracked.
  function automatic logic [REGNO_BITS-1:0] f_map(input logic [REGNO_BITS-1:0] idx);
    f_map = (32'(idx) < NUM_REGS) ? idx : '0;
  endfunction

  always_comb begin : p_release
    logic [REGNO_BITS-1:0] v_reg;
    v_reg = '0;
    for (int r = 0; r < NUM_REGS; r++) w_rel[r] = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      v_reg = f_map(sb.wb_regno_i[k*REGNO_BITS +: REGNO_BITS]);
      if (sb.wb_valid_i[k] && (v_reg != '0))
        w_rel[v_reg] = w_rel[v_reg] + c_rel_bits'(1);
    end
  end

  always_comb begin : p_hazard
    logic [REGNO_BITS-1:0] v_src;
    logic [c_sum_bits-1:0] v_eff;
    v_src        = '0;
    v_eff        = '0;
    w_src_hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_src = f_map(sb.src_regno_i[k*REGNO_BITS +: REGNO_BITS]);
      v_eff = c_sum_bits'(w_count[v_src]);
      if (WB_BYPASS != 0)
        v_eff = v_eff - c_sum_bits'(w_rel[v_src]);
      if (sb.src_use_i[k] && (v_src != '0) && (v_eff != '0))
        w_src_hazard = 1'b1;
    end
  end

  // Saturation gets no writeback credit: the freed slot is usable next cycle.
  assign w_dst        = f_map(sb.issue_dst_i);
  assign w_sat_hazard = sb.issue_wr_i && (w_dst != '0) && (w_count[w_dst] == c_cnt_max);
  assign w_stall      = sb.issue_valid_i && !sb.flush_i && (w_src_hazard || w_sat_hazard);
  assign w_fire       = sb.issue_valid_i && !sb.flush_i && !w_stall;

  assign sb.stall_o         = w_stall;
  assign sb.issue_fire_o    = w_fire;
  assign sb.err_underflow_o = r_err;

  always_comb begin : p_busy
    sb.busy_vec_o = '0;
    w_uf_any      = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb.busy_vec_o[r] = (w_count[r] != '0);
      w_uf_any         = w_uf_any | w_uf[r];
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_count[r] = '0;
      assign w_uf[r]    = 1'b0;
    end else begin : g_cnt
      logic [CNT_BITS-1:0]   r_count;
      logic                  w_inc;
      logic [c_sum_bits-1:0] w_sum;

      assign w_inc   = w_fire && sb.issue_wr_i && (w_dst == REGNO_BITS'(r));
      assign w_sum   = c_sum_bits'(r_count) + c_sum_bits'(w_inc);
      assign w_uf[r] = (c_sum_bits'(w_rel[r]) > w_sum);

      always_ff @(posedge clk) begin
        if (!reset)
          r_count <= '0;
        else if (w_uf[r])
          r_count <= '0;
        else
          r_count <= CNT_BITS'(w_sum - c_sum_bits'(w_rel[r]));
      end

      assign w_count[r] = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_err <= 1'b0;
    else
      r_err <= r_err | w_uf_any;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Drives a no-bypass and a bypass scoreboard against a counter model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_scoreboard;

  localparam int NUM_REGS   = 24;
  localparam int REGNO_BITS = 5;
  localparam int CNT_BITS   = 2;
  localparam int NUM_SRC    = 2;
  localparam int NUM_WB     = 2;
  localparam int CMAX       = (1 << CNT_BITS) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .REGNO_BITS(REGNO_BITS),
                      .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB)) sb0 ();
  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .REGNO_BITS(REGNO_BITS),
                      .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB)) sb1 ();

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .REGNO_BITS(REGNO_BITS), .CNT_BITS(CNT_BITS),
                   .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .WB_BYPASS(0))
    dut0 (.clk(clk), .reset(reset), .sb(sb0));
  reg_scoreboard #(.NUM_REGS(NUM_REGS), .REGNO_BITS(REGNO_BITS), .CNT_BITS(CNT_BITS),
                   .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .WB_BYPASS(1))
    dut1 (.clk(clk), .reset(reset), .sb(sb1));

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 1'b0;
  int m_cnt [2][NUM_REGS];
  bit m_err [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int map_reg(input int idx);
    return (idx < NUM_REGS) ? idx : 0;
  endfunction

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
  endfunction

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cyc(input string tag, input bit rn, input bit v, input bit wr, input int dst,
                     input bit [1:0] use_, input int s0, input int s1, input bit fl,
                     input bit [1:0] wbv, input int w0, input int w1);
    int                  rel [NUM_REGS];
    int                  src [2];
    int                  eff, sr, n, dm;
    bit                  hz;
    bit                  es [2];
    bit                  ef [2];
    logic [NUM_REGS-1:0] eb;

    reset = rn;
    sb0.issue_valid_i = v;   sb1.issue_valid_i = v;
    sb0.issue_wr_i    = wr;  sb1.issue_wr_i    = wr;
    sb0.issue_dst_i   = 5'(dst);            sb1.issue_dst_i   = 5'(dst);
    sb0.src_use_i     = use_;               sb1.src_use_i     = use_;
    sb0.src_regno_i   = {5'(s1), 5'(s0)};   sb1.src_regno_i   = {5'(s1), 5'(s0)};
    sb0.flush_i       = fl;  sb1.flush_i       = fl;
    sb0.wb_valid_i    = wbv; sb1.wb_valid_i    = wbv;
    sb0.wb_regno_i    = {5'(w1), 5'(w0)};   sb1.wb_regno_i    = {5'(w1), 5'(w0)};
    #2;

    foreach (rel[r]) rel[r] = 0;
    if (wbv[0] && map_reg(w0 & 31) != 0) rel[map_reg(w0 & 31)]++;
    if (wbv[1] && map_reg(w1 & 31) != 0) rel[map_reg(w1 & 31)]++;
    src[0] = map_reg(s0 & 31);
    src[1] = map_reg(s1 & 31);
    dm     = map_reg(dst & 31);

    for (int d = 0; d < 2; d++) begin
      hz = 1'b0;
      for (int k = 0; k < 2; k++) begin
        sr = src[k];
        if (use_[k] && sr != 0) begin
          eff = m_cnt[d][sr] - ((d == 1) ? rel[sr] : 0);
          if (eff != 0) hz = 1'b1;
        end
      end
      if (wr && dm != 0 && m_cnt[d][dm] == CMAX) hz = 1'b1;
      es[d] = v && !fl && hz;
      ef[d] = v && !fl && !hz;
    end

    if (armed) begin
      for (int r = 0; r < NUM_REGS; r++) eb[r] = (m_cnt[0][r] != 0);
      check_eq({tag, "/stall0"}, sb0.stall_o, es[0]);
      check_eq({tag, "/fire0"},  sb0.issue_fire_o, ef[0]);
      check_eq({tag, "/busy0"},  sb0.busy_vec_o, eb);
      check_eq({tag, "/err0"},   sb0.err_underflow_o, m_err[0]);
      for (int r = 0; r < NUM_REGS; r++) eb[r] = (m_cnt[1][r] != 0);
      check_eq({tag, "/stall1"}, sb1.stall_o, es[1]);
      check_eq({tag, "/fire1"},  sb1.issue_fire_o, ef[1]);
      check_eq({tag, "/busy1"},  sb1.busy_vec_o, eb);
      check_eq({tag, "/err1"},   sb1.err_underflow_o, m_err[1]);
    end

    for (int d = 0; d < 2; d++) begin
      if (!rn) begin
        for (int r = 0; r < NUM_REGS; r++) m_cnt[d][r] = 0;
        m_err[d] = 1'b0;
      end else begin
        for (int r = 1; r < NUM_REGS; r++) begin
          n = m_cnt[d][r] + ((ef[d] && wr && dm == r) ? 1 : 0) - rel[r];
          if (n < 0) begin
            n        = 0;
            m_err[d] = 1'b1;
          end
          m_cnt[d][r] = n;
        end
      end
    end
    if (!rn) armed = 1'b1;

    @(posedge clk);
    #1;
  endtask

  initial begin
    //       tag      rn v  wr dst use    s0 s1 fl wbv    w0 w1
    cyc("rst",   0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("rst",   0, 1, 1, 5, 2'b11, 3, 4, 0, 2'b11, 3, 4);
    cyc("t1",    1, 1, 0, 0, 2'b11, 3, 4, 0, 2'b00, 0, 0);
    check_eq("t1_busy_zero", sb0.busy_vec_o, '0);

    cyc("t2_wr5",  1, 1, 1, 5, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t2_rd5",  1, 1, 0, 0, 2'b01, 5, 0, 0, 2'b00, 0, 0);
    cyc("t2_rd5",  1, 1, 0, 0, 2'b10, 0, 5, 0, 2'b00, 0, 0);
    cyc("t2_wb5",  1, 1, 0, 0, 2'b01, 5, 0, 0, 2'b01, 5, 0);
    cyc("t2_aft",  1, 1, 0, 0, 2'b01, 5, 0, 0, 2'b00, 0, 0);

    cyc("t3_wr7",  1, 1, 1, 7, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t3_wr7",  1, 1, 1, 7, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t3_wb7",  1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 0, 7);
    check_eq("t3_busy7_after_one_wb", sb0.busy_vec_o[7], 1'b1);
    cyc("t3_wb7",  1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 7, 0);
    check_eq("t3_busy7_after_two_wb", sb1.busy_vec_o[7], 1'b0);

    for (int i = 0; i < 3; i++)
      cyc("t4_wr9", 1, 1, 1, 9, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t4_sat",  1, 1, 1, 9, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t4_satw", 1, 1, 1, 9, 2'b00, 0, 0, 0, 2'b01, 9, 0);
    cyc("t4_fire", 1, 1, 1, 9, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t4_drn",  1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 9, 9);
    cyc("t4_drn",  1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 9, 0);

    cyc("t5_wr6",  1, 1, 1, 6, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t5_wr2",  1, 1, 1, 2, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    cyc("t5_fl",   1, 1, 1, 6, 2'b01, 6, 0, 1, 2'b01, 2, 0);
    check_eq("t5_busy2_cleared", sb0.busy_vec_o[2], 1'b0);
    check_eq("t5_busy6_kept",    sb0.busy_vec_o[6], 1'b1);

    cyc("t6_uf",   1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 11, 0);
    check_eq("t6_err_set", sb0.err_underflow_o, 1'b1);
    cyc("t6_x0",   1, 1, 1, 0, 2'b11, 0, 0, 0, 2'b11, 0, 30);
    cyc("t6_oor",  1, 1, 1, 28, 2'b11, 29, 0, 0, 2'b00, 0, 0);
    check_eq("t6_err_sticky", sb1.err_underflow_o, 1'b1);
    cyc("t6_rst",  0, 1, 1, 3, 2'b01, 6, 0, 0, 2'b01, 6, 0);
    check_eq("t6_rst_busy", sb0.busy_vec_o, '0);
    check_eq("t6_rst_err",  sb0.err_underflow_o, 1'b0);

    for (int i = 0; i < 3000; i++)
      cyc("rnd", $urandom_range(0, 99) >= 3, $urandom_range(0, 9) < 8,
          $urandom_range(0, 9) < 7, rnd_reg(), 2'($urandom), rnd_reg(), rnd_reg(),
          $urandom_range(0, 9) == 0,
          {1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 4)},
          rnd_reg(), rnd_reg());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised register-busy scoreboard for the in-order RISC-V pipeline, instantiated inside the DE stage. It replaces ad-hoc per-register busy bits with per-register in-flight writer counters and supports N source operands and M writeback ports. It also offers optional same-cycle writeback bypass of the stall, saturation back-pressure and an underflow error flag. It produces the DE stall sent to FE and the issue-fire qualifier for the DE latch.

Parameters:
NUM_REGS, 32, architectural registers tracked; register 0 never becomes busy.
REGNO_BITS, 5, register index width; NUM_REGS <= 2**REGNO_BITS.
CNT_BITS, 3, per-register in-flight writer counter width; CNT_MAX = 2**CNT_BITS-1.
NUM_SRC, 2, source operand read ports checked per issue.
NUM_WB, 1, writeback (release) ports per cycle.
WB_BYPASS, 0, 1 = a source released by writeback this cycle does not stall.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset; state clears when reset==0 at posedge.
issue_valid_i  in  1  DE holds a valid decoded instruction.
issue_wr_i  in  1  instruction writes a destination register.
issue_dst_i  in  REGNO_BITS  destination register index.
src_use_i  in  NUM_SRC  per-source "operand is a register read" flag.
src_regno_i  in  NUM_SRC*REGNO_BITS  source indices; port k at bits [k*REGNO_BITS +: REGNO_BITS].
flush_i  in  1  branch clear from AGEX; squashes the DE instruction this cycle.
wb_valid_i  in  NUM_WB  per-port register write completing in WB.
wb_regno_i  in  NUM_WB*REGNO_BITS  per-port written register index.
stall_o  out  1  combinational; DE must hold and FE must stall.
issue_fire_o  out  1  combinational; DE latch captures the instruction this cycle.
busy_vec_o  out  NUM_REGS  registered-state view; bit r = (count[r] != 0).
err_underflow_o  out  1  sticky; a release hit a zero counter.

Behaviour:
- State: count[r] of CNT_BITS for r = 1..NUM_REGS-1. count[0] is constant 0.
- Reset (reset==0 at posedge): all counts = 0 and err_underflow_o = 0. Consequently busy_vec_o = 0, and stall_o = 0 for any inputs. Reset overrides all same-cycle issue, release and flush events.
- rel[r] = number of wb ports k with wb_valid_i[k] && wb_regno_i[k]==r && r!=0. Each matching port counts once; duplicates on the same r sum.
- Source hazard, port k: src_use_i[k] && src_regno_i[k]!=0 && eff[k] != 0.
  - WB_BYPASS=0: eff[k] = count.
  - WB_BYPASS=1: eff[k] = count - rel for that register.
- Saturation hazard: issue_wr_i && issue_dst_i!=0 && count[issue_dst_i]==CNT_MAX, with no bypass credit.
- stall_o = issue_valid_i && !flush_i && (any source hazard || saturation hazard).
- issue_fire_o = issue_valid_i && !flush_i && !stall_o.
- A flushed instruction never increments a count and is never reported as stalled. Flush does not alter existing counts, because older in-flight writers still retire.
- inc[r] = issue_fire_o && issue_wr_i && issue_dst_i==r && r!=0.
- Next state: count[r] <= count[r] + inc[r] - rel[r].
  - Simultaneous issue and release to the same r: net change = 1 - rel.
  - If rel[r] > count[r] + inc[r]: clamp count[r] to 0 and set err_underflow_o, which stays 1 until reset.
- Latency:
  - An issued write makes its destination busy from the next cycle.
  - A release clears busy from the next cycle, or in the same cycle when WB_BYPASS=1.
- Writes to, or reads of, register 0 never stall and never change state.
- Indices >= NUM_REGS are treated as register 0.
- No other state is kept.

Test Plan:
1. Reset held low 2 cycles, then released; issue_valid_i=1, src regs 3/4 -> stall_o=0, busy_vec_o=0, issue_fire_o=1.
2. Issue wr x5; next cycle issue with src x5 -> stall_o=1 until wb_valid_i[0]=1, wb_regno_i=5. WB_BYPASS=0: stall drops the cycle after WB. WB_BYPASS=1: stall drops in the WB cycle.
3. Issue wr x7 twice back-to-back, then one WB to x7 -> busy_vec_o[7] stays 1. A second WB -> busy_vec_o[7]=0.
4. With CNT_BITS=2, issue wr x9 three times, then a fourth wr x9 -> stall_o=1, count stays 3. WB x9 -> next cycle the fourth issue fires.
5. flush_i=1 with issue wr x6 and src x6 busy -> stall_o=0, issue_fire_o=0, count[6] unchanged. Same cycle WB x2 still decrements count[2].
6. WB x11 with count 0 -> err_underflow_o=1 and stays 1. Issue wr x0 plus WB x0 -> no change. Reset low mid-traffic -> all counts 0 and err cleared.
